// File: rtl/rr_grant_scheduler.sv
// -----------------------------------------------------------------------------
// rr_grant_scheduler
//   Round-robin arbiter sharing one resource among M = 2**N requesters.
//   A registered binary grant index is decoded into a one-hot grant vector.
//   A hold quantum (MAX_HOLD cycles) limits how long one requester keeps the
//   resource while others are waiting.
//
// Ports
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   req          in   M   request vector, bit i = requester i
//   grant        out  M   one-hot grant, all-zero when grant_valid = 0
//   grant_idx    out  N   binary index of the current grant holder
//   grant_valid  out  1   a grant is active this cycle
// -----------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [(1<<N)-1:0]  req,
    output logic [(1<<N)-1:0]  grant,
    output logic [N-1:0]       grant_idx,
    output logic               grant_valid
);

    localparam int M  = 1 << N;
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    last_ptr, last_nxt;
    logic [N-1:0]    idx_nxt;
    logic            valid_nxt;
    logic [M-1:0]    grant_nxt;
    logic [HW-1:0]   hold_cnt, hold_nxt;

    // Returns {found, index} of the first set bit of r, scanning from base+1
    // upward and wrapping M-1 -> 0. Scanning offsets from largest to smallest
    // lets the nearest candidate overwrite the result last.
    function automatic logic [N:0] rr_search(input logic [M-1:0] r,
                                             input logic [N-1:0] base);
        logic [N:0]   res;
        logic [N-1:0] j;
        res = '0;
        for (int k = M; k >= 1; k--) begin
            j = base + N'(k);
            if (r[j]) res = {1'b1, j};
        end
        return res;
    endfunction

    logic [M-1:0] others;
    logic [N:0]   pick_all;
    logic [N:0]   pick_oth;

    // Requests from everyone except the current holder; only looked at when
    // the holder releases or its quantum expires.
    assign others   = req & ~(M'(1) << grant_idx);
    assign pick_all = rr_search(req, last_ptr);
    assign pick_oth = rr_search(others, last_ptr);

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        last_nxt  = last_ptr;
        idx_nxt   = grant_idx;
        valid_nxt = grant_valid;
        hold_nxt  = hold_cnt;

        unique case (state)
            IDLE: begin
                if (pick_all[N]) begin
                    idx_nxt   = pick_all[N-1:0];
                    last_nxt  = pick_all[N-1:0];
                    valid_nxt = 1'b1;
                    hold_nxt  = HW'(1);
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    // Release wins over quantum expiry; hand over with no bubble.
                    if (pick_oth[N]) begin
                        idx_nxt  = pick_oth[N-1:0];
                        last_nxt = pick_oth[N-1:0];
                        hold_nxt = HW'(1);
                    end else begin
                        valid_nxt = 1'b0;
                        hold_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end else if (hold_cnt == HW'(MAX_HOLD)) begin
                    // Quantum expired: preempt if anyone else waits, otherwise
                    // the holder simply starts a fresh quantum.
                    if (pick_oth[N]) begin
                        idx_nxt  = pick_oth[N-1:0];
                        last_nxt = pick_oth[N-1:0];
                    end
                    hold_nxt = HW'(1);
                end else begin
                    hold_nxt = hold_cnt + HW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        grant_nxt = valid_nxt ? (M'(1) << idx_nxt) : '0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_ptr    <= N'(M - 1);
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            grant       <= '0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            last_ptr    <= last_nxt;
            grant_idx   <= idx_nxt;
            grant_valid <= valid_nxt;
            grant       <= grant_nxt;
            hold_cnt    <= hold_nxt;
        end
    end

endmodule
